// File: rtl/pbuf_pkg.sv
// Shared definitions for the ping/pang/pung packet-buffer scheduler.
package pbuf_pkg;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_PING = 2'b01;
  localparam logic [1:0] SEL_PANG = 2'b10;
  localparam logic [1:0] SEL_PUNG = 2'b11;
  localparam int NUM_BUF = 3;

  typedef enum logic [2:0] {
    BUF_FREE, BUF_SN, BUF_WAIT_CPU, BUF_CPU, BUF_WAIT_FWD, BUF_FWD
  } buf_state_t;

  // Buffer index 0..2 maps to sel 01..11.
  function automatic logic [1:0] idx2sel(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

  function automatic logic [1:0] sel2idx(input logic [1:0] sel);
    return sel - 2'd1;
  endfunction
endpackage

// File: rtl/pbuf_scheduler_if.sv
// Agent-facing pulses and buffer-ownership outputs of the packet-buffer scheduler.
interface pbuf_scheduler_if #(parameter int LEN_WIDTH = 13);
  logic                 sn_done;
  logic [LEN_WIDTH-1:0] sn_len;
  logic                 cpu_acc;
  logic                 cpu_rej;
  logic                 fwd_done;
  logic [1:0]           sn_sel;
  logic [1:0]           cpu_sel;
  logic [1:0]           fwd_sel;
  logic [LEN_WIDTH-1:0] cpu_len;
  logic [LEN_WIDTH-1:0] fwd_len;
  logic                 err;

  modport master (
    output sn_done, sn_len, cpu_acc, cpu_rej, fwd_done,
    input  sn_sel, cpu_sel, fwd_sel, cpu_len, fwd_len, err
  );

  modport slave (
    input  sn_done, sn_len, cpu_acc, cpu_rej, fwd_done,
    output sn_sel, cpu_sel, fwd_sel, cpu_len, fwd_len, err
  );
endinterface

// File: rtl/pbuf_scheduler_idx_fifo.sv
// 3-deep FIFO of 2-bit buffer indices; an empty FIFO passes a same-cycle push
// straight to the pop side so a released buffer can be granted in the same edge.
module idx_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] push_idx,
  input  logic       pop,
  output logic       pop_vld,
  output logic [1:0] pop_idx
);
  logic [2:0][1:0] mem_q, mem_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            empty;

  assign empty   = (cnt_q == 2'd0);
  assign pop_vld = !empty || push;
  assign pop_idx = empty ? push_idx : mem_q[0];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop && !empty) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = mem_q[2];
      cnt_d    = cnt_q - 2'd1;
    end
    // A push consumed by pass-through never touches storage.
    if (push && !(pop && empty) && cnt_d != 2'd3) begin
      mem_d[cnt_d] = push_idx;
      cnt_d        = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pbuf_scheduler.sv
// Rotates three packet buffers between snooper, CPU and forwarder; releases
// are applied first each edge, then grants are made on the post-release state.
module pbuf_scheduler
  import pbuf_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 3
) (
  input logic              clk,
  input logic              rst,
  pbuf_scheduler_if.slave  bus
);
  buf_state_t           st_q [NUM_BUF];
  buf_state_t           st_rel [NUM_BUF];
  buf_state_t           st_d [NUM_BUF];
  logic [LEN_WIDTH-1:0] len_q [NUM_BUF];
  logic [LEN_WIDTH-1:0] len_d [NUM_BUF];
  logic [1:0]           sn_sel_q, sn_sel_d, sn_rel;
  logic [1:0]           cpu_sel_q, cpu_sel_d, cpu_rel;
  logic [1:0]           fwd_sel_q, fwd_sel_d, fwd_rel;
  logic [LEN_WIDTH-1:0] cpu_len_q, cpu_len_d, fwd_len_q, fwd_len_d;
  logic                 err_q, err_d;
  logic                 cq_push, cq_pop, cq_vld, fq_push, fq_pop, fq_vld;
  logic [1:0]           cq_push_idx, cq_idx, fq_push_idx, fq_idx;

  idx_fifo u_wait_cpu (
    .clk(clk), .rst(rst), .push(cq_push), .push_idx(cq_push_idx),
    .pop(cq_pop), .pop_vld(cq_vld), .pop_idx(cq_idx)
  );

  idx_fifo u_wait_fwd (
    .clk(clk), .rst(rst), .push(fq_push), .push_idx(fq_push_idx),
    .pop(fq_pop), .pop_vld(fq_vld), .pop_idx(fq_idx)
  );

  // Release phase; kept apart from grants so FIFO pass-through is not a comb loop.
  always_comb begin
    st_rel      = st_q;
    len_d       = len_q;
    sn_rel      = sn_sel_q;
    cpu_rel     = cpu_sel_q;
    fwd_rel     = fwd_sel_q;
    err_d       = err_q;
    cq_push     = 1'b0;
    cq_push_idx = sel2idx(sn_sel_q);
    fq_push     = 1'b0;
    fq_push_idx = sel2idx(cpu_sel_q);
    if (bus.sn_done) begin
      if (sn_sel_q == SEL_NONE) err_d = 1'b1;
      else begin
        st_rel[sel2idx(sn_sel_q)] = BUF_WAIT_CPU;
        len_d[sel2idx(sn_sel_q)]  = bus.sn_len;
        cq_push = 1'b1;
        sn_rel  = SEL_NONE;
      end
    end
    if (bus.cpu_acc && bus.cpu_rej) err_d = 1'b1;
    if (bus.cpu_acc || bus.cpu_rej) begin
      if (cpu_sel_q == SEL_NONE) err_d = 1'b1;
      else begin
        cpu_rel = SEL_NONE;
        if (bus.cpu_rej) st_rel[sel2idx(cpu_sel_q)] = BUF_FREE;
        else begin
          st_rel[sel2idx(cpu_sel_q)] = BUF_WAIT_FWD;
          fq_push = 1'b1;
        end
      end
    end
    if (bus.fwd_done) begin
      if (fwd_sel_q == SEL_NONE) err_d = 1'b1;
      else begin
        st_rel[sel2idx(fwd_sel_q)] = BUF_FREE;
        fwd_rel = SEL_NONE;
      end
    end
  end

  // Grant phase.
  always_comb begin
    st_d      = st_rel;
    sn_sel_d  = sn_rel;
    cpu_sel_d = cpu_rel;
    fwd_sel_d = fwd_rel;
    cq_pop    = 1'b0;
    fq_pop    = 1'b0;
    if (sn_rel == SEL_NONE) begin
      for (int i = NUM_BUF - 1; i >= 0; i--)
        if (st_rel[i] == BUF_FREE) sn_sel_d = idx2sel(2'(i));
      if (sn_sel_d != SEL_NONE) st_d[sel2idx(sn_sel_d)] = BUF_SN;
    end
    if (cpu_rel == SEL_NONE && cq_vld) begin
      cq_pop         = 1'b1;
      cpu_sel_d      = idx2sel(cq_idx);
      st_d[cq_idx]   = BUF_CPU;
    end
    if (fwd_rel == SEL_NONE && fq_vld) begin
      fq_pop         = 1'b1;
      fwd_sel_d      = idx2sel(fq_idx);
      st_d[fq_idx]   = BUF_FWD;
    end
  end

  always_comb begin
    cpu_len_d = '0;
    fwd_len_d = '0;
    if (cpu_sel_d != SEL_NONE) cpu_len_d = len_d[sel2idx(cpu_sel_d)];
    if (fwd_sel_d != SEL_NONE) fwd_len_d = len_d[sel2idx(fwd_sel_d)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]   <= BUF_SN;
      st_q[1]   <= BUF_FREE;
      st_q[2]   <= BUF_FREE;
      len_q     <= '{default: '0};
      sn_sel_q  <= SEL_PING;
      cpu_sel_q <= SEL_NONE;
      fwd_sel_q <= SEL_NONE;
      cpu_len_q <= '0;
      fwd_len_q <= '0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      len_q     <= len_d;
      sn_sel_q  <= sn_sel_d;
      cpu_sel_q <= cpu_sel_d;
      fwd_sel_q <= fwd_sel_d;
      cpu_len_q <= cpu_len_d;
      fwd_len_q <= fwd_len_d;
      err_q     <= err_d;
    end
  end

  assign bus.sn_sel  = sn_sel_q;
  assign bus.cpu_sel = cpu_sel_q;
  assign bus.fwd_sel = fwd_sel_q;
  assign bus.cpu_len = cpu_len_q;
  assign bus.fwd_len = fwd_len_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_pbuf_scheduler.sv
// Scoreboard bench: driver updates an ownership/queue model and queues expected
// outputs; a monitor compares the DUT against them one cycle later.
module tb_pbuf_scheduler;
  localparam int LW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pbuf_scheduler_if #(.LEN_WIDTH(LW)) bus();
  pbuf_scheduler #(.ADDR_WIDTH(10), .LEN_WIDTH(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]    sn, cpu, fwd;
    logic [LW-1:0] cl, fl;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model: which buffer each agent owns (-1 = none) plus two FIFO wait lists.
  int            m_sn, m_cpu, m_fwd;
  int            m_wc[$];
  int            m_wf[$];
  logic [LW-1:0] m_len [3];
  logic          m_err;

  function automatic bit m_free(int b);
    if (b == m_sn || b == m_cpu || b == m_fwd) return 1'b0;
    foreach (m_wc[i]) if (m_wc[i] == b) return 1'b0;
    foreach (m_wf[i]) if (m_wf[i] == b) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] own2sel(int o);
    return (o < 0) ? 2'd0 : 2'(o + 1);
  endfunction

  task automatic step(input bit r, input bit sd, input logic [LW-1:0] sl,
                      input bit ca, input bit cr, input bit fd);
    exp_t e;
    @(negedge clk);
    rst = r; bus.sn_done = sd; bus.sn_len = sl;
    bus.cpu_acc = ca; bus.cpu_rej = cr; bus.fwd_done = fd;
    if (r) begin
      m_sn = 0; m_cpu = -1; m_fwd = -1;
      m_wc.delete(); m_wf.delete();
      foreach (m_len[i]) m_len[i] = '0;
      m_err = 1'b0;
    end else begin
      if (sd) begin
        if (m_sn < 0) m_err = 1'b1;
        else begin m_len[m_sn] = sl; m_wc.push_back(m_sn); m_sn = -1; end
      end
      if (ca && cr) m_err = 1'b1;
      if (ca || cr) begin
        if (m_cpu < 0) m_err = 1'b1;
        else begin
          if (!cr) m_wf.push_back(m_cpu);
          m_cpu = -1;
        end
      end
      if (fd) begin
        if (m_fwd < 0) m_err = 1'b1;
        else m_fwd = -1;
      end
      if (m_sn < 0)
        for (int b = 0; b < 3; b++)
          if (m_sn < 0 && m_free(b)) m_sn = b;
      if (m_cpu < 0 && m_wc.size() > 0) m_cpu = m_wc.pop_front();
      if (m_fwd < 0 && m_wf.size() > 0) m_fwd = m_wf.pop_front();
    end
    e.sn  = own2sel(m_sn);
    e.cpu = own2sel(m_cpu);
    e.fwd = own2sel(m_fwd);
    e.cl  = (m_cpu < 0) ? '0 : m_len[m_cpu];
    e.fl  = (m_fwd < 0) ? '0 : m_len[m_fwd];
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
  endtask

  // Monitor: every edge after the first driven cycle yields one output vector.
  exp_t mon_e;
  bit   mon_bad;
  bit   mon_dup;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_dup = (bus.sn_sel != 2'd0 && (bus.sn_sel == bus.cpu_sel || bus.sn_sel == bus.fwd_sel)) ||
                (bus.cpu_sel != 2'd0 && bus.cpu_sel == bus.fwd_sel);
      mon_bad = mon_dup || bus.sn_sel !== mon_e.sn || bus.cpu_sel !== mon_e.cpu ||
                bus.fwd_sel !== mon_e.fwd || bus.cpu_len !== mon_e.cl ||
                bus.fwd_len !== mon_e.fl || bus.err !== mon_e.err;
      n_vec++;
      if (mon_bad) begin
        n_bad++;
        $display("FAIL outputs vec %0d t=%0t: got sn=%0d cpu=%0d fwd=%0d cl=%0d fl=%0d err=%0b dup=%0b, want sn=%0d cpu=%0d fwd=%0d cl=%0d fl=%0d err=%0b",
                 n_vec, $time, bus.sn_sel, bus.cpu_sel, bus.fwd_sel, bus.cpu_len, bus.fwd_len,
                 bus.err, mon_dup, mon_e.sn, mon_e.cpu, mon_e.fwd, mon_e.cl, mon_e.fl, mon_e.err);
      end
    end
  end

  initial begin
    bus.sn_done = 1'b0; bus.sn_len = '0; bus.cpu_acc = 1'b0;
    bus.cpu_rej = 1'b0; bus.fwd_done = 1'b0;
    m_sn = 0; m_cpu = -1; m_fwd = -1; m_err = 1'b0;
    foreach (m_len[i]) m_len[i] = '0;

    // reset then idle
    step(1, 0, '0, 0, 0, 0); step(1, 0, '0, 0, 0, 0); idle(2);
    // single packet through CPU to forwarder
    step(0, 1, 13'd64, 0, 0, 0); idle(1);
    step(0, 0, '0, 1, 0, 0); idle(2);
    // all buffers filled, CPU stalled, then reject
    step(1, 0, '0, 0, 0, 0);
    step(0, 1, 13'd10, 0, 0, 0); step(0, 1, 13'd20, 0, 0, 0); step(0, 1, 13'd30, 0, 0, 0);
    idle(2);
    step(0, 0, '0, 0, 1, 0); idle(1);
    // three-way rotation in one edge
    step(1, 0, '0, 0, 0, 0);
    step(0, 1, 13'd5, 0, 0, 0); step(0, 1, 13'd6, 0, 0, 0); step(0, 0, '0, 1, 0, 0);
    step(0, 1, 13'd7, 1, 0, 1); idle(1);
    // protocol errors are sticky; acc+rej frees the buffer
    step(1, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 1); idle(1);
    step(0, 1, 13'd9, 0, 0, 0); step(0, 0, '0, 1, 1, 0); idle(2);
    // reset mid-flow
    step(1, 0, '0, 0, 0, 0);
    step(0, 1, 13'd11, 0, 0, 0); step(0, 0, '0, 1, 0, 0); step(0, 1, 13'd12, 0, 0, 0);
    step(1, 1, 13'd99, 1, 0, 1); idle(2);

    // randomized traffic with occasional illegal pulses and resets
    for (int i = 0; i < 3000; i++) begin
      bit r, sd, ca, cr, fd;
      int k;
      r  = ($urandom_range(0, 199) == 0);
      sd = (m_sn >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      k  = $urandom_range(0, 99);
      if (m_cpu >= 0) begin
        ca = (k < 30) || (k == 99);
        cr = (k >= 30 && k < 40) || (k == 99);
      end else begin
        ca = (k == 0);
        cr = 1'b0;
      end
      fd = (m_fwd >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      step(r, sd, LW'($urandom), ca, cr, fd);
    end
    idle(1);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
